cpu_mem_sequencer: RTL and testbench

- Multicycle sequencer that lets the single-cycle CPU core share one single-port unified memory for instruction fetch, data access and a boot loader.
- Per instruction it fetches from the CPU PC, latches the instruction, and runs at most one data access.
- It then pulses the CPU `ena` for exactly one cycle, which commits PC and regfile updates.
- Sits between the CPU core's IMEM/DMEM pins and the shared memory with its ready handshake.

---
 rtl/cpu_mem_sequencer_if.sv | 22 ++
 rtl/cpu_mem_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cpu_mem_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_sequencer_if.sv
// Shared single-port memory bus between the sequencer (master) and the unified memory (slave).
interface cpu_mem_sequencer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cpu_mem_sequencer.sv
// Multicycle sequencer sharing one memory port between instruction fetch,
// one data access per instruction and a boot loader; pulses cpu_ena to commit.
module cpu_mem_sequencer #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [AW-1:0]       cpu_pc,
    input  logic                cpu_dm_ena,
    input  logic                cpu_dm_w,
    input  logic                cpu_dm_r,
    input  logic [AW-1:0]       cpu_dm_addr,
    input  logic [DW-1:0]       cpu_dm_data_w,
    output logic [DW-1:0]       cpu_instr,
    output logic [DW-1:0]       cpu_dm_data,
    output logic                cpu_ena,
    input  logic                ld_req,
    input  logic [AW-1:0]       ld_addr,
    input  logic [DW-1:0]       ld_data,
    output logic                ld_ack,
    cpu_mem_sequencer_if.master mem,
    output logic                busy,
    output logic                err,
    output logic [31:0]         instr_cnt
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DATA, COMMIT, LOAD, HALT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cpu_instr_q, cpu_instr_d;
    logic [DW-1:0] cpu_dm_data_q, cpu_dm_data_d;
    logic [31:0]   instr_cnt_q, instr_cnt_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic [CW-1:0] wait_inc;
    logic          req_c, we_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;

    // State and latch registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= IDLE;
            cpu_instr_q   <= '0;
            cpu_dm_data_q <= '0;
            instr_cnt_q   <= '0;
            wait_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_instr_q   <= cpu_instr_d;
            cpu_dm_data_q <= cpu_dm_data_d;
            instr_cnt_q   <= instr_cnt_d;
            wait_q        <= wait_d;
            err_q         <= err_d;
        end
    end

    // Memory bus decode from state only; idle bus is driven to zero
    always_comb begin
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            FETCH: begin
                req_c  = 1'b1;
                addr_c = cpu_pc;
            end
            DATA: begin
                if (cpu_dm_ena) begin
                    req_c   = 1'b1;
                    we_c    = cpu_dm_w;
                    addr_c  = cpu_dm_addr;
                    wdata_c = cpu_dm_data_w;
                end
            end
            LOAD: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = ld_addr;
                wdata_c = ld_data;
            end
            default: ;
        endcase
    end

    // Next state, capture latches, wait counter and handshake pulses
    always_comb begin
        state_d       = state_q;
        cpu_instr_d   = cpu_instr_q;
        cpu_dm_data_d = cpu_dm_data_q;
        instr_cnt_d   = instr_cnt_q;
        wait_d        = wait_q;
        err_d         = err_q;
        cpu_ena       = 1'b0;
        ld_ack        = 1'b0;
        wait_inc      = wait_q + CW'(1);
        case (state_q)
            IDLE: begin
                // Loader wins only between instructions
                if (ld_req) begin
                    state_d = LOAD;
                    wait_d  = '0;
                end else if (run && !err_q) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                if (mem.mem_ready) begin
                    cpu_instr_d = mem.mem_rdata;
                    wait_d      = '0;
                    state_d     = DATA;
                end else if (wait_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            DATA: begin
                if (!cpu_dm_ena) begin
                    state_d = COMMIT;
                end else if (mem.mem_ready) begin
                    // A simultaneous read+write is a write: nothing captured
                    if (cpu_dm_r && !cpu_dm_w) begin
                        cpu_dm_data_d = mem.mem_rdata;
                    end
                    state_d = COMMIT;
                end else if (wait_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            COMMIT: begin
                cpu_ena     = 1'b1;
                instr_cnt_d = instr_cnt_q + 32'd1;
                state_d     = IDLE;
            end
            LOAD: begin
                if (mem.mem_ready) begin
                    ld_ack  = 1'b1;
                    state_d = IDLE;
                end else if (wait_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;

    assign cpu_instr   = cpu_instr_q;
    assign cpu_dm_data = cpu_dm_data_q;
    assign instr_cnt   = instr_cnt_q;
    assign err         = err_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Scoreboard bench for cpu_mem_sequencer: directed instruction stream with a
// wait-state memory model; a negedge monitor checks every bus completion and commit.
module tb_cpu_mem_sequencer;
    localparam int C_ENA  = 0;
    localparam int C_REQ  = 1;
    localparam int C_ACK  = 2;
    localparam int C_ERR  = 3;
    localparam int C_DREQ = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] dm_data;
        logic [31:0] cnt;
    } commit_exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic [31:0] cpu_pc, cpu_dm_addr, cpu_dm_data_w, cpu_instr, cpu_dm_data;
    logic        cpu_dm_ena, cpu_dm_w, cpu_dm_r, cpu_ena;
    logic        ld_req, ld_ack, busy, err;
    logic [31:0] ld_addr, ld_data, instr_cnt;

    cpu_mem_sequencer_if #(.AW(32), .DW(32)) bus ();

    cpu_mem_sequencer #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .cpu_pc(cpu_pc), .cpu_dm_ena(cpu_dm_ena), .cpu_dm_w(cpu_dm_w), .cpu_dm_r(cpu_dm_r),
        .cpu_dm_addr(cpu_dm_addr), .cpu_dm_data_w(cpu_dm_data_w),
        .cpu_instr(cpu_instr), .cpu_dm_data(cpu_dm_data), .cpu_ena(cpu_ena),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .mem(bus), .busy(busy), .err(err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: addresses equal to slow_addr take wait_cfg wait cycles
    logic [31:0] mem_arr [64];
    bit          mem_loaded;
    int unsigned wcnt;
    int unsigned wait_cfg;
    int unsigned need;
    logic [31:0] slow_addr;

    always_comb begin
        need          = (bus.mem_addr == slow_addr) ? wait_cfg : 0;
        bus.mem_ready = bus.mem_req && (wcnt >= need);
        bus.mem_rdata = bus.mem_ready ? mem_arr[bus.mem_addr[7:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
            mem_arr[0]  <= 32'h2001_0005;
            mem_arr[1]  <= 32'h8C02_0008;
            mem_arr[2]  <= 32'hDEAD_BEEF;
            mem_arr[3]  <= 32'hAC01_0010;
            mem_arr[5]  <= 32'h1111_1111;
            mem_arr[8]  <= 32'hAC03_0014;
            mem_loaded  <= 1'b1;
        end else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
            mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
        if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Scoreboard queues filled by stimulus, drained by the monitor
    mem_exp_t    exp_mem[$];
    commit_exp_t exp_commit[$];
    chk_t        chk_q[$];
    int          checks;
    int          failures;
    int          ack_cnt;
    bit          mon_en;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: bus completions, commits, idle-bus cleanliness, queued direct checks
    always @(negedge clk) begin
        mem_exp_t    m;
        commit_exp_t k;
        chk_t        c;
        if (mon_en) begin
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                compare(c.name, c.act, c.exp);
            end
            if (!bus.mem_req)
                compare("idle_bus_zero",
                        64'((bus.mem_we || bus.mem_addr != 0 || bus.mem_wdata != 0) ? 1 : 0), 64'd0);
            if (bus.mem_req && bus.mem_ready) begin
                if (exp_mem.size() == 0) begin
                    compare("unexpected_mem_txn", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    m = exp_mem.pop_front();
                    compare("mem_we", 64'(bus.mem_we), 64'(m.we));
                    compare("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
                    compare("mem_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
                end
            end
            if (cpu_ena) begin
                if (exp_commit.size() == 0) begin
                    compare("unexpected_commit", 64'(cpu_instr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    k = exp_commit.pop_front();
                    compare("commit_instr", 64'(cpu_instr), 64'(k.instr));
                    compare("commit_dm_data", 64'(cpu_dm_data), 64'(k.dm_data));
                    compare("commit_cnt", 64'(instr_cnt), 64'(k.cnt));
                end
            end
            if (ld_ack) ack_cnt++;
        end
    end

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.wdata = wdata;
        exp_mem.push_back(m);
    endtask

    task automatic push_commit(input logic [31:0] instr, input logic [31:0] dm, input logic [31:0] cnt);
        commit_exp_t k;
        k.instr = instr; k.dm_data = dm; k.cnt = cnt;
        exp_commit.push_back(k);
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic ena, input logic w, input logic r,
                             input logic [31:0] addr, input logic [31:0] wdata);
        cpu_pc = pc; cpu_dm_ena = ena; cpu_dm_w = w; cpu_dm_r = r;
        cpu_dm_addr = addr; cpu_dm_data_w = wdata;
    endtask

    function automatic logic hit(input int cond);
        case (cond)
            C_ENA:   return cpu_ena;
            C_REQ:   return bus.mem_req;
            C_ACK:   return ld_ack;
            C_ERR:   return err;
            default: return bus.mem_req && !bus.mem_we && (bus.mem_addr == 32'h8);
        endcase
    endfunction

    // Bounded wait in negedges; an expired bound becomes a failed check
    task automatic wait_for(input int cond, input int max, input string name, output int edges);
        edges = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (hit(cond)) begin
                edges = i;
                return;
            end
        end
        expect_eq({name, "_bound_expired"}, 64'd0, 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int e;
        rst_n = 1'b1; run = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
        slow_addr = 32'hFFFF_FFFF; wait_cfg = 0;
        set_instr(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b0;
        mon_en = 1'b1;
        expect_eq("rst_busy", 64'(busy), 64'd0);
        expect_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
        expect_eq("rst_cpu_ena", 64'(cpu_ena), 64'd0);
        expect_eq("rst_ld_ack", 64'(ld_ack), 64'd0);
        expect_eq("rst_err", 64'(err), 64'd0);
        expect_eq("rst_instr_cnt", 64'(instr_cnt), 64'd0);
        expect_eq("rst_cpu_instr", 64'(cpu_instr), 64'd0);
        expect_eq("rst_cpu_dm_data", 64'(cpu_dm_data), 64'd0);

        // addi $1,$0,5 at 0x0, zero-wait: commit in the 4th cycle
        push_mem(1'b0, 32'h0, 32'h0);
        push_commit(32'h2001_0005, 32'h0, 32'd0);
        run = 1'b1;
        wait_for(C_ENA, 20, "commit0", e);
        expect_eq("lat_first_commit", 64'(e), 64'd3);

        // lw $2,8($0) at 0x4 with 3 data wait cycles: 7 cycles
        set_instr(32'h4, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
        slow_addr = 32'h8; wait_cfg = 3;
        push_mem(1'b0, 32'h4, 32'h0);
        push_mem(1'b0, 32'h8, 32'h0);
        push_commit(32'h8C02_0008, 32'hDEAD_BEEF, 32'd1);
        wait_for(C_ENA, 20, "commit1", e);
        expect_eq("gap_lw_3wait", 64'(e), 64'd7);

        // sw $1,0x10($0) at 0xC: write issued, load latch unchanged
        slow_addr = 32'hFFFF_FFFF; wait_cfg = 0;
        set_instr(32'hC, 1'b1, 1'b1, 1'b0, 32'h10, 32'h5);
        push_mem(1'b0, 32'hC, 32'h0);
        push_mem(1'b1, 32'h10, 32'h5);
        push_commit(32'hAC01_0010, 32'hDEAD_BEEF, 32'd2);
        wait_for(C_ENA, 20, "commit2", e);
        expect_eq("gap_sw", 64'(e), 64'd4);

        // read+write together at 0x20 is a write, no capture
        set_instr(32'h20, 1'b1, 1'b1, 1'b1, 32'h14, 32'hA5A5_A5A5);
        push_mem(1'b0, 32'h20, 32'h0);
        push_mem(1'b1, 32'h14, 32'hA5A5_A5A5);
        push_commit(32'hAC03_0014, 32'hDEAD_BEEF, 32'd3);
        wait_for(C_ENA, 20, "commit3", e);
        expect_eq("gap_rw_as_write", 64'(e), 64'd4);
        expect_eq("sw_stored", 64'(mem_arr[4]), 64'd5);

        // Loader request during a stalled fetch: instruction commits first
        set_instr(32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        slow_addr = 32'h10; wait_cfg = 2;
        push_mem(1'b0, 32'h10, 32'h0);
        push_commit(32'h0000_0005, 32'hDEAD_BEEF, 32'd4);
        push_mem(1'b1, 32'h40, 32'h1234_5678);
        wait_for(C_REQ, 20, "fetch4", e);
        ld_addr = 32'h40; ld_data = 32'h1234_5678; ld_req = 1'b1;
        wait_for(C_ENA, 20, "commit4", e);
        slow_addr = 32'hFFFF_FFFF; wait_cfg = 0;
        set_instr(32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push_mem(1'b0, 32'h14, 32'h0);
        push_commit(32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'd5);
        wait_for(C_ACK, 20, "ld_ack", e);
        expect_eq("gap_commit_to_ack", 64'(e), 64'd2);
        ld_req = 1'b0;
        wait_for(C_REQ, 20, "fetch5", e);
        expect_eq("gap_ack_to_fetch", 64'(e), 64'd2);

        // run dropped mid-instruction: still commits, then stays idle
        run = 1'b0;
        wait_for(C_ENA, 20, "commit5", e);
        expect_eq("gap_fetch_to_commit", 64'(e), 64'd2);
        repeat (5) @(negedge clk);
        expect_eq("idle_after_run_drop", 64'(busy), 64'd0);
        expect_eq("instr_cnt_6", 64'(instr_cnt), 64'd6);
        expect_eq("ld_ack_once", 64'(ack_cnt), 64'd1);
        expect_eq("loader_stored", 64'(mem_arr[16]), 64'h1234_5678);

        // Fetch never answered: error after 15 wait cycles, halted
        set_instr(32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        slow_addr = 32'h24; wait_cfg = 1000;
        run = 1'b1;
        wait_for(C_ERR, 40, "err", e);
        expect_eq("err_latency", 64'(e), 64'd16);
        expect_eq("halt_mem_req", 64'(bus.mem_req), 64'd0);
        expect_eq("halt_busy", 64'(busy), 64'd1);
        expect_eq("halt_instr_cnt", 64'(instr_cnt), 64'd6);
        repeat (5) @(negedge clk);
        expect_eq("err_sticky", 64'(err), 64'd1);
        expect_eq("halt_stays", 64'(busy), 64'd1);
        run = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        expect_eq("err_cleared", 64'(err), 64'd0);
        expect_eq("cnt_cleared", 64'(instr_cnt), 64'd0);
        expect_eq("busy_cleared", 64'(busy), 64'd0);
        expect_eq("dm_data_cleared", 64'(cpu_dm_data), 64'd0);

        // Reset during a stalled data read abandons the instruction
        set_instr(32'h4, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
        slow_addr = 32'h8; wait_cfg = 1000;
        push_mem(1'b0, 32'h4, 32'h0);
        run = 1'b1;
        wait_for(C_DREQ, 20, "data_req", e);
        expect_eq("gap_to_data_req", 64'(e), 64'd2);
        run = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        expect_eq("abort_mem_req", 64'(bus.mem_req), 64'd0);
        expect_eq("abort_cpu_ena", 64'(cpu_ena), 64'd0);
        expect_eq("abort_cpu_instr", 64'(cpu_instr), 64'd0);
        expect_eq("abort_busy", 64'(busy), 64'd0);

        repeat (3) @(negedge clk);
        expect_eq("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        expect_eq("commit_queue_drained", 64'(exp_commit.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
